// File: rtl/dse_record_decoder.sv
// Receive-side decoder for the DSE endpoint output stream.
// Each strobed word is split into {magic, payload}. A small FSM tracks the run
// phase. DEG payloads are buffered in a first-word-fall-through FIFO for a
// valid/ready consumer. The perf snapshot is captured from the finish word.
// Protocol violations are reported, and per-phase counters are kept.
module dse_record_decoder #(
   parameter int DEG_DATA_WIDTH  = 256,
   parameter int MAGIC_NUM_WIDTH = 8,
   parameter int PERF_DATA_WIDTH = 128,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      in_enable,
   input  logic [DEG_DATA_WIDTH+MAGIC_NUM_WIDTH-1:0] in_data,
   output logic                                      deg_valid,
   input  logic                                      deg_ready,
   output logic [DEG_DATA_WIDTH-1:0]                 deg_data,
   output logic [1:0]                                phase,
   output logic                                      perf_valid,
   output logic [PERF_DATA_WIDTH-1:0]                perf_data,
   output logic [31:0]                               deg_count,
   output logic [15:0]                               drop_count,
   output logic                                      err_valid,
   output logic [2:0]                                err_code,
   output logic                                      err_sticky
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [MAGIC_NUM_WIDTH-1:0] MAGIC_EMULATE = MAGIC_NUM_WIDTH'(1);
   localparam logic [MAGIC_NUM_WIDTH-1:0] MAGIC_DEG     = MAGIC_NUM_WIDTH'(2);
   localparam logic [MAGIC_NUM_WIDTH-1:0] MAGIC_DEGDONE = MAGIC_NUM_WIDTH'(3);
   localparam logic [MAGIC_NUM_WIDTH-1:0] MAGIC_FINISH  = MAGIC_NUM_WIDTH'(4);

   localparam logic [2:0] ERR_BAD_MAGIC         = 3'd1;
   localparam logic [2:0] ERR_DEG_OUT_OF_PHASE  = 3'd2;
   localparam logic [2:0] ERR_DONE_OUT_OF_PHASE = 3'd3;
   localparam logic [2:0] ERR_EMULATE_REENTRY   = 3'd4;
   localparam logic [2:0] ERR_FINISH_IN_RECORD  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EMULATE = 2'd1,
      ST_RECORD  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Decoded input fields
   logic [MAGIC_NUM_WIDTH-1:0] magic;
   logic [DEG_DATA_WIDTH-1:0]  payload;
   assign magic   = in_data[DEG_DATA_WIDTH+MAGIC_NUM_WIDTH-1 -: MAGIC_NUM_WIDTH];
   assign payload = in_data[DEG_DATA_WIDTH-1:0];

   // FSM and decode control
   state_t     state_reg, state_next;
   logic       push_req;
   logic       perf_fire;
   logic       clear_counts;
   logic       err_fire;
   logic [2:0] err_code_next;

   // FIFO storage and bookkeeping
   logic [DEG_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic [CW-1:0]             count_reg, count_next;
   logic [DEG_DATA_WIDTH-1:0] deg_data_reg, head_next;
   logic                      pop, full, push_eff, drop;

   // Registered outputs
   logic [PERF_DATA_WIDTH-1:0] perf_data_reg;
   logic                       perf_valid_reg;
   logic [31:0]                deg_count_reg;
   logic [15:0]                drop_count_reg;
   logic                       err_valid_reg, err_sticky_reg;
   logic [2:0]                 err_code_reg;

   // Phase register
   always_ff @(posedge clock) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // Word decode: next phase, FIFO push request, perf capture, error selection
   always_comb begin
      state_next    = state_reg;
      push_req      = 1'b0;
      perf_fire     = 1'b0;
      clear_counts  = 1'b0;
      err_fire      = 1'b0;
      err_code_next = 3'd0;
      if (in_enable) begin
         case (magic)
            MAGIC_EMULATE: begin
               state_next   = ST_EMULATE;
               clear_counts = 1'b1;
               if (state_reg == ST_EMULATE || state_reg == ST_RECORD) begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_EMULATE_REENTRY;
               end
            end
            MAGIC_DEG: begin
               if (state_reg == ST_EMULATE || state_reg == ST_RECORD) begin
                  state_next = ST_RECORD;
                  push_req   = 1'b1;
               end else begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_DEG_OUT_OF_PHASE;
               end
            end
            MAGIC_DEGDONE: begin
               if (state_reg == ST_EMULATE || state_reg == ST_RECORD) begin
                  state_next = ST_DONE;
               end else begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_DONE_OUT_OF_PHASE;
               end
            end
            MAGIC_FINISH: begin
               state_next = ST_IDLE;
               perf_fire  = 1'b1;
               if (state_reg == ST_RECORD) begin
                  err_fire      = 1'b1;
                  err_code_next = ERR_FINISH_IN_RECORD;
               end
            end
            default: begin
               err_fire      = 1'b1;
               err_code_next = ERR_BAD_MAGIC;
            end
         endcase
      end
   end

   // FIFO next-state: a pop frees a slot in the same cycle, so push+pop when full never drops
   always_comb begin
      pop         = (count_reg != '0) && deg_ready;
      full        = (count_reg == CW'(FIFO_DEPTH));
      push_eff    = push_req && (!full || pop);
      drop        = push_req && !push_eff;
      wr_ptr_next = push_eff ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      count_next  = count_reg;
      case ({push_eff, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
      // The next head is either already in memory or is the word being written now
      if (push_eff && (wr_ptr_reg == rd_ptr_next)) head_next = payload;
      else                                         head_next = mem[rd_ptr_next];
   end

   // FIFO storage write; pointers alone define validity, so the array needs no reset
   always_ff @(posedge clock) begin
      if (push_eff) mem[wr_ptr_reg] <= payload;
   end

   // FIFO pointers, occupancy and registered head word
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         deg_data_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         if (count_next != '0) deg_data_reg <= head_next;
      end
   end

   // Per-phase counters, saturating at all-ones
   always_ff @(posedge clock) begin
      if (reset || clear_counts) begin
         deg_count_reg  <= '0;
         drop_count_reg <= '0;
      end else begin
         if (push_req && (deg_count_reg != '1))   deg_count_reg  <= deg_count_reg + 32'd1;
         if (drop && (drop_count_reg != '1))      drop_count_reg <= drop_count_reg + 16'd1;
      end
   end

   // Perf snapshot capture and error reporting
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_data_reg  <= '0;
         perf_valid_reg <= 1'b0;
         err_valid_reg  <= 1'b0;
         err_code_reg   <= 3'd0;
         err_sticky_reg <= 1'b0;
      end else begin
         perf_valid_reg <= perf_fire;
         if (perf_fire) perf_data_reg <= in_data[PERF_DATA_WIDTH-1:0];
         err_valid_reg <= err_fire;
         if (err_fire) begin
            err_code_reg   <= err_code_next;
            err_sticky_reg <= 1'b1;
         end
      end
   end

   assign deg_valid  = (count_reg != '0);
   assign deg_data   = deg_data_reg;
   assign phase      = state_reg;
   assign perf_valid = perf_valid_reg;
   assign perf_data  = perf_data_reg;
   assign deg_count  = deg_count_reg;
   assign drop_count = drop_count_reg;
   assign err_valid  = err_valid_reg;
   assign err_code   = err_code_reg;
   assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_dse_record_decoder.sv
// Directed bench for dse_record_decoder: a vector table for the main stream,
// the error and re-entry cases, and hand-written fill/drain/reset sequences.
module tb_dse_record_decoder;

   localparam int DW = 256;
   localparam int MW = 8;
   localparam int PW = 128;
   localparam int FD = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              in_enable;
   logic [DW+MW-1:0]  in_data;
   logic              deg_valid;
   logic              deg_ready;
   logic [DW-1:0]     deg_data;
   logic [1:0]        phase;
   logic              perf_valid;
   logic [PW-1:0]     perf_data;
   logic [31:0]       deg_count;
   logic [15:0]       drop_count;
   logic              err_valid;
   logic [2:0]        err_code;
   logic              err_sticky;

   int errors = 0;
   int checks = 0;

   dse_record_decoder #(
      .DEG_DATA_WIDTH(DW), .MAGIC_NUM_WIDTH(MW), .PERF_DATA_WIDTH(PW), .FIFO_DEPTH(FD)
   ) dut (
      .clock(clock), .reset(reset), .in_enable(in_enable), .in_data(in_data),
      .deg_valid(deg_valid), .deg_ready(deg_ready), .deg_data(deg_data),
      .phase(phase), .perf_valid(perf_valid), .perf_data(perf_data),
      .deg_count(deg_count), .drop_count(drop_count),
      .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        en;
      logic [7:0]  magic;
      logic [15:0] payload;
      logic        ready;
      logic [1:0]  phase;
      logic        dvalid;
      logic [15:0] ddata;
      logic [31:0] dcount;
      logic        evalid;
      logic [2:0]  ecode;
      logic        pvalid;
      logic [15:0] pdata;
      logic        sticky;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic en, logic [7:0] m, logic [15:0] p, logic rdy,
                               logic [1:0] ph, logic dv, logic [15:0] dd, logic [31:0] dc,
                               logic ev, logic [2:0] ec, logic pv, logic [15:0] pd, logic st);
      vec_t r;
      r.en = en; r.magic = m; r.payload = p; r.ready = rdy;
      r.phase = ph; r.dvalid = dv; r.ddata = dd; r.dcount = dc;
      r.evalid = ev; r.ecode = ec; r.pvalid = pv; r.pdata = pd; r.sticky = st;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one word (or an idle cycle), then sample #1 after the capturing edge
   task automatic drive(input logic en, input logic [7:0] m, input logic [15:0] p);
      in_enable = en;
      in_data   = {m, 240'd0, p};
      @(posedge clock);
      #1;
      in_enable = 1'b0;
   endtask

   initial begin
      int n;
      logic [15:0] last;

      reset = 1'b1; in_enable = 1'b0; in_data = '0; deg_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_deg_valid", 64'(deg_valid), 64'd0);
      chk("rst_deg_data", deg_data[63:0], 64'd0);
      chk("rst_perf", perf_data[63:0], 64'd0);
      chk("rst_counts", 64'({deg_count, drop_count}), 64'd0);
      chk("rst_err", 64'({err_valid, err_code, err_sticky, perf_valid}), 64'd0);
      reset = 1'b0;

      // en magic payload rdy | phase dv ddata dcount ev ec pv pdata sticky
      vecs.push_back(mk(1, 8'd1, 16'h0000, 1, 2'd1, 0, 16'h0,    0, 0, 3'd0, 0, 16'h0,    0));
      vecs.push_back(mk(1, 8'd2, 16'h00A1, 1, 2'd2, 1, 16'hA1,   1, 0, 3'd0, 0, 16'h0,    0));
      vecs.push_back(mk(1, 8'd2, 16'h00A2, 1, 2'd2, 1, 16'hA2,   2, 0, 3'd0, 0, 16'h0,    0));
      vecs.push_back(mk(1, 8'd2, 16'h00A3, 1, 2'd2, 1, 16'hA3,   3, 0, 3'd0, 0, 16'h0,    0));
      vecs.push_back(mk(1, 8'd3, 16'h0000, 1, 2'd3, 0, 16'h0,    3, 0, 3'd0, 0, 16'h0,    0));
      vecs.push_back(mk(1, 8'd4, 16'h1234, 1, 2'd0, 0, 16'h0,    3, 0, 3'd0, 1, 16'h1234, 0));
      vecs.push_back(mk(0, 8'd0, 16'h0000, 1, 2'd0, 0, 16'h0,    3, 0, 3'd0, 0, 16'h1234, 0));
      // out-of-phase and bad magic from IDLE
      vecs.push_back(mk(1, 8'd2, 16'h00C1, 1, 2'd0, 0, 16'h0,    3, 1, 3'd2, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd3, 16'h0000, 1, 2'd0, 0, 16'h0,    3, 1, 3'd3, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd7, 16'h0000, 1, 2'd0, 0, 16'h0,    3, 1, 3'd1, 0, 16'h1234, 1));
      vecs.push_back(mk(0, 8'd0, 16'h0000, 1, 2'd0, 0, 16'h0,    3, 0, 3'd1, 0, 16'h1234, 1));
      // re-entry and finish in RECORD, consumer stalled
      vecs.push_back(mk(1, 8'd1, 16'h0000, 0, 2'd1, 0, 16'h0,    0, 0, 3'd1, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd2, 16'h00B1, 0, 2'd2, 1, 16'hB1,   1, 0, 3'd1, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd1, 16'h0000, 0, 2'd1, 1, 16'hB1,   0, 1, 3'd4, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd2, 16'h00B2, 0, 2'd2, 1, 16'hB1,   1, 0, 3'd4, 0, 16'h1234, 1));
      vecs.push_back(mk(1, 8'd4, 16'h5678, 0, 2'd0, 1, 16'hB1,   1, 1, 3'd5, 1, 16'h5678, 1));
      vecs.push_back(mk(0, 8'd0, 16'h0000, 1, 2'd0, 1, 16'hB2,   1, 0, 3'd5, 0, 16'h5678, 1));
      vecs.push_back(mk(0, 8'd0, 16'h0000, 1, 2'd0, 0, 16'h0,    1, 0, 3'd5, 0, 16'h5678, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         deg_ready = vecs[i].ready;
         drive(vecs[i].en, vecs[i].magic, vecs[i].payload);
         $display("vec %0d: magic=%0d phase=%0d deg_valid=%0b deg_count=%0d err=%0b/%0d",
                  i, vecs[i].magic, phase, deg_valid, deg_count, err_valid, err_code);
         chk($sformatf("v%0d_phase", i), 64'(phase), 64'(vecs[i].phase));
         chk($sformatf("v%0d_deg_valid", i), 64'(deg_valid), 64'(vecs[i].dvalid));
         if (vecs[i].dvalid)
            chk($sformatf("v%0d_deg_data", i), deg_data[63:0], 64'(vecs[i].ddata));
         chk($sformatf("v%0d_deg_count", i), 64'(deg_count), 64'(vecs[i].dcount));
         chk($sformatf("v%0d_err_valid", i), 64'(err_valid), 64'(vecs[i].evalid));
         chk($sformatf("v%0d_err_code", i), 64'(err_code), 64'(vecs[i].ecode));
         chk($sformatf("v%0d_perf_valid", i), 64'(perf_valid), 64'(vecs[i].pvalid));
         chk($sformatf("v%0d_perf_data", i), perf_data[63:0], 64'(vecs[i].pdata));
         chk($sformatf("v%0d_sticky", i), 64'(err_sticky), 64'(vecs[i].sticky));
         chk($sformatf("v%0d_drop", i), 64'(drop_count), 64'd0);
      end

      // Overfill with consumer stalled: 20 words, 4 dropped, first 16 drain in order
      deg_ready = 1'b0;
      drive(1'b1, 8'd1, 16'h0);
      for (int i = 0; i < 20; i++) drive(1'b1, 8'd2, 16'h0100 + 16'(i));
      $display("overfill: deg_count=%0d drop_count=%0d", deg_count, drop_count);
      chk("ovf_deg_count", 64'(deg_count), 64'd20);
      chk("ovf_drop_count", 64'(drop_count), 64'd4);
      chk("ovf_valid", 64'(deg_valid), 64'd1);
      deg_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d_valid", i), 64'(deg_valid), 64'd1);
         chk($sformatf("drain%0d_data", i), deg_data[63:0], 64'h0100 + 64'(i));
         @(posedge clock);
         #1;
      end
      $display("drain: deg_valid=%0b after 16 pops", deg_valid);
      chk("drain_empty", 64'(deg_valid), 64'd0);

      // Full FIFO, push and pop on the same edge: no drop, occupancy stays 16
      deg_ready = 1'b0;
      drive(1'b1, 8'd1, 16'h0);
      for (int i = 0; i < 16; i++) drive(1'b1, 8'd2, 16'h0200 + 16'(i));
      chk("full_drop0", 64'(drop_count), 64'd0);
      deg_ready = 1'b1;
      drive(1'b1, 8'd2, 16'h02FF);
      $display("full push+pop: deg_count=%0d drop_count=%0d head=%0h", deg_count, drop_count, deg_data[15:0]);
      chk("fpp_drop", 64'(drop_count), 64'd0);
      chk("fpp_deg_count", 64'(deg_count), 64'd17);
      chk("fpp_head", deg_data[63:0], 64'h0201);
      n = 0;
      last = '0;
      for (int k = 0; k < 40 && deg_valid; k++) begin
         n++;
         last = deg_data[15:0];
         @(posedge clock);
         #1;
      end
      $display("full push+pop drain: %0d entries, last=%0h", n, last);
      chk("fpp_occupancy", 64'(n), 64'd16);
      chk("fpp_last", 64'(last), 64'h02FF);

      // Reset mid-RECORD with buffered records
      deg_ready = 1'b0;
      drive(1'b1, 8'd1, 16'h0);
      for (int i = 0; i < 5; i++) drive(1'b1, 8'd2, 16'h0300 + 16'(i));
      chk("pre_rst_phase", 64'(phase), 64'd2);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      $display("mid-phase reset: phase=%0d deg_valid=%0b sticky=%0b", phase, deg_valid, err_sticky);
      chk("mrst_deg_valid", 64'(deg_valid), 64'd0);
      chk("mrst_phase", 64'(phase), 64'd0);
      chk("mrst_counts", 64'({deg_count, drop_count}), 64'd0);
      chk("mrst_sticky", 64'(err_sticky), 64'd0);
      chk("mrst_err_code", 64'(err_code), 64'd0);
      chk("mrst_perf", perf_data[63:0], 64'd0);
      chk("mrst_deg_data", deg_data[63:0], 64'd0);
      @(posedge clock);
      #1;
      chk("mrst_still_empty", 64'(deg_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
